data_mem_sync: RTL and testbench

//  Single-port synchronous data memory for the 32-bit datapath; MEM stage issues load/store requests.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 35 +++
 rtl/data_mem_sync.sv | 146 ++++++++++++++
 tb/tb_data_mem_sync.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the synchronous data memory.
// Optional feature macro: DMEM_ERR_EN (error qualifier on responses).
package dmem_pkg;

  localparam int DMEM_AWIDTH = 32;
  localparam int DMEM_DWIDTH = 32;
  localparam int DMEM_DEPTH  = 128;
  localparam int NBYTES      = DMEM_DWIDTH / 8;
  localparam int IDXW        = $clog2(DMEM_DEPTH);

  typedef enum logic {
    INIT,
    READY
  } dmem_state_t;

  // Word number of a byte address; low two bits are dropped.
  function automatic logic [DMEM_AWIDTH-1:0] word_idx(
    input logic [DMEM_AWIDTH-1:0] addr
  );
    return addr >> 2;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-lane writes and a registered read port.
// Optional feature macro: DMEM_ERR_EN (handled in data_mem_sync).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DWIDTH = DMEM_DWIDTH,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [DWIDTH/8-1:0]        wbe,
  input  logic [$clog2(DEPTH)-1:0]   widx,
  input  logic [DWIDTH-1:0]          wdat,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   ridx,
  output logic [DWIDTH-1:0]          rdat
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Byte-lane write and registered read; contents cleared by the top's sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DWIDTH / 8; i++) begin
        if (wbe[i]) begin
          mem[widx][i*8 +: 8] <= wdat[i*8 +: 8];
        end
      end
    end
    if (re) begin
      rdat <= mem[ridx];
    end
  end

endmodule

// File: rtl/data_mem_sync.sv
// Single-port synchronous data memory with handshake and clear sweep.
// Optional feature macro: DMEM_ERR_EN (RspErr on bad loads, drops bad stores).
module data_mem_sync
  import dmem_pkg::*;
#(
  parameter int AWIDTH = DMEM_AWIDTH,
  parameter int DWIDTH = DMEM_DWIDTH,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                ReqVal,
  output logic                ReqRdy,
  input  logic                WE2,
  input  logic [DWIDTH/8-1:0] ByteEn,
  input  logic [AWIDTH-1:0]   Addr,
  input  logic [DWIDTH-1:0]   WriDat,
  output logic                RspVal,
  output logic [DWIDTH-1:0]   ReaDat,
  output logic                RspErr
);

  localparam int NB = DWIDTH / 8;
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  dmem_state_t state;
  logic [IW-1:0] cnt;

  logic [DMEM_AWIDTH-1:0] wnum;
  logic [IW-1:0] idx;
  logic acc;
  logic re;
  logic oor;
  logic bad;
  logic zero_w;

  logic          we;
  logic [NB-1:0] wbe;
  logic [IW-1:0] widx;
  logic [DWIDTH-1:0] wdat;

  logic [DWIDTH-1:0] rdat;
  logic rsp_q;
  logic rd_zero;

  assign ReqRdy = (state == READY);
  assign acc    = ReqVal & ReqRdy & ~Rst;
  assign re     = acc & ~WE2;

  assign wnum   = word_idx(DMEM_AWIDTH'(Addr));
  assign idx    = wnum[IW-1:0];
  assign oor    = (wnum >= DMEM_AWIDTH'(DEPTH));
  assign zero_w = (idx == '0);

`ifdef DMEM_ERR_EN
  logic mis;
  logic err_q;
  logic err_seen;

  assign mis = |Addr[1:0];
  assign bad = oor | mis;

  // Error qualifier for the response and sticky error history.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_q    <= 1'b0;
      err_seen <= 1'b0;
    end else begin
      err_q <= re & bad;
      if (acc & bad) begin
        err_seen <= 1'b1;
      end
    end
  end

  assign RspErr = err_q;
`else
  assign bad    = oor;
  assign RspErr = 1'b0;
`endif

  // Clear sweep and init-to-ready transition.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state <= READY;
      end
    end
  end

  // Write port: sweep zeros during init, else accepted good stores.
  always_comb begin
    we   = 1'b0;
    wbe  = '0;
    widx = idx;
    wdat = WriDat;
    unique case (1'b1)
      (state == INIT): begin
        we   = 1'b1;
        wbe  = '1;
        widx = cnt;
        wdat = '0;
      end
      default: begin
        we  = acc & WE2 & ~bad & ~zero_w;
        wbe = ByteEn;
      end
    endcase
  end

  // Response pulse and zero-forcing for word 0 / bad loads.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rsp_q   <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      rsp_q <= re;
      if (re) begin
        rd_zero <= bad | zero_w;
      end
    end
  end

  assign RspVal = rsp_q;
  assign ReaDat = rd_zero ? '0 : rdat;

  dmem_array #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk  (Clk),
    .we   (we),
    .wbe  (wbe),
    .widx (widx),
    .wdat (wdat),
    .re   (re),
    .ridx (idx),
    .rdat (rdat)
  );

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed table-driven bench for data_mem_sync.
// Optional feature macro: DMEM_ERR_EN (changes expected RspErr/data).
module tb_data_mem_sync;

`ifdef DMEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ReqVal = 1'b0;
  logic        ReqRdy;
  logic        WE2 = 1'b0;
  logic [3:0]  ByteEn = 4'h0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriDat = 32'h0;
  logic        RspVal;
  logic [31:0] ReaDat;
  logic        RspErr;

  int total = 0;
  int passed = 0;
  logic [31:0] last_dat = 32'h0;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] dat;
    logic        chk_dat;
    logic        err;
  } vec_t;

  vec_t tbl[20];

  data_mem_sync dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .ReqVal (ReqVal),
    .ReqRdy (ReqRdy),
    .WE2    (WE2),
    .ByteEn (ByteEn),
    .Addr   (Addr),
    .WriDat (WriDat),
    .RspVal (RspVal),
    .ReaDat (ReaDat),
    .RspErr (RspErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    ReqVal = 1'b1;
    WE2    = v.we;
    ByteEn = v.be;
    Addr   = v.addr;
    WriDat = v.wdat;
    @(posedge Clk);
    #1;
    ReqVal = 1'b0;
    if (v.we) begin
      chk({nm, " st rspval"}, 32'(RspVal), 32'd0);
      chk({nm, " st hold"}, ReaDat, last_dat);
    end else begin
      chk({nm, " ld rspval"}, 32'(RspVal), 32'd1);
      if (v.chk_dat) begin
        chk({nm, " ld dat"}, ReaDat, v.dat);
      end
      chk({nm, " ld err"}, 32'(RspErr), 32'(v.err));
      last_dat = ReaDat;
    end
  endtask

  task automatic wait_init(input string nm);
    int n;
    bit saw;
    n = 0;
    saw = 1'b0;
    while (ReqRdy !== 1'b1 && n < 300) begin
      if (RspVal) saw = 1'b1;
      @(posedge Clk);
      #1;
      n++;
    end
    ReqVal = 1'b0;
    chk({nm, " init cycles"}, 32'(n), 32'd128);
    chk({nm, " init no rsp"}, 32'(saw), 32'd0);
  endtask

  function automatic vec_t st(input logic [31:0] a,
                              input logic [31:0] d,
                              input logic [3:0] be);
    vec_t v;
    v = '{1'b1, be, a, d, 32'h0, 1'b0, 1'b0};
    return v;
  endfunction

  function automatic vec_t ld(input logic [31:0] a,
                              input logic [31:0] d,
                              input logic cd,
                              input logic e);
    vec_t v;
    v = '{1'b0, 4'h0, a, 32'h0, d, cd, e};
    return v;
  endfunction

  initial begin
    tbl[0]  = ld(32'h000, 32'h0, 1'b1, 1'b0);
    tbl[1]  = ld(32'h1FC, 32'h0, 1'b1, 1'b0);
    tbl[2]  = st(32'h010, 32'hDEADBEEF, 4'hF);
    tbl[3]  = ld(32'h010, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[4]  = st(32'h010, 32'h00000055, 4'b0001);
    tbl[5]  = ld(32'h010, 32'hDEADBE55, 1'b1, 1'b0);
    tbl[6]  = st(32'h000, 32'hFFFFFFFF, 4'hF);
    tbl[7]  = ld(32'h000, 32'h0, 1'b1, 1'b0);
    tbl[8]  = st(32'h000, 32'h000000FF, 4'b0001);
    tbl[9]  = ld(32'h000, 32'h0, 1'b1, 1'b0);
    tbl[10] = st(32'h200, 32'h00001234, 4'hF);
    tbl[11] = ld(32'h200, 32'h0, 1'b1, ERR);
    tbl[12] = st(32'h1FC, 32'hA5A50F0F, 4'b1100);
    tbl[13] = ld(32'h1FC, 32'hA5A50000, 1'b1, 1'b0);
    tbl[14] = st(32'h014, 32'h11223344, 4'b0110);
    tbl[15] = ld(32'h014, 32'h00223300, 1'b1, 1'b0);
    tbl[16] = ld(32'h010, 32'hDEADBE55, 1'b1, 1'b0);
    tbl[17] = ld(32'h013, 32'hDEADBE55, !ERR, ERR);
    tbl[18] = st(32'h012, 32'hFFFFFFFF, 4'hF);
    tbl[19] = ld(32'h010,
                 ERR ? 32'hDEADBE55 : 32'hFFFFFFFF,
                 1'b1, 1'b0);

    Rst    = 1'b1;
    ReqVal = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("rst reqrdy", 32'(ReqRdy), 32'd0);
    chk("rst rspval", 32'(RspVal), 32'd0);
    chk("rst readat", ReaDat, 32'h0);
    chk("rst rsperr", 32'(RspErr), 32'd0);
    wait_init("boot");

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    @(posedge Clk);
    #1;
    chk("pulse end", 32'(RspVal), 32'd0);
    chk("hold dat", ReaDat, last_dat);

    ReqVal = 1'b1;
    WE2    = 1'b0;
    Addr   = 32'h20;
    @(posedge Clk);
    #1;
    chk("pre-rst rspval", 32'(RspVal), 32'd1);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("rst drop rspval", 32'(RspVal), 32'd0);
    chk("rst drop reqrdy", 32'(ReqRdy), 32'd0);
    WE2    = 1'b1;
    ByteEn = 4'hF;
    Addr   = 32'h18;
    WriDat = 32'hFFFFFFFF;
    wait_init("reinit");
    last_dat = 32'h0;
    apply(ld(32'h010, 32'h0, 1'b1, 1'b0), "clr 0x10");
    apply(ld(32'h018, 32'h0, 1'b1, 1'b0), "ign 0x18");
    apply(ld(32'h1FC, 32'h0, 1'b1, 1'b0), "clr 0x1FC");

    @(posedge Clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
